// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } muldiv_state_e;

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

  function automatic logic op_is_div(input muldiv_op_e op);
    return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
  endfunction

  function automatic logic op_is_rem(input muldiv_op_e op);
    return (op inside {OP_REM, OP_REMU});
  endfunction

  // MUL keeps both operands unsigned: its low word is sign-agnostic
  function automatic logic a_is_signed(input muldiv_op_e op);
    return (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  endfunction

  function automatic logic b_is_signed(input muldiv_op_e op);
    return (op inside {OP_MULH, OP_DIV, OP_REM});
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? ({XLEN{1'b0}} - v) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide unit.
interface ex_muldiv_unit_if;
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            flush;
  logic            stall_req;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, op_a, op_b, rd_in, flush,
    input  stall_req, busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in, flush,
    output stall_req, busy, done, result, rd_out
  );

endinterface

// File: rtl/ex_muldiv_unit.sv
// Radix-2 iterative RV32M unit: one product/quotient bit per cycle on operand
// magnitudes, sign fix on the last iteration, divide special cases bypass iteration.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int ITERS = XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  ex_muldiv_unit_if.slave   mdu
);
  import muldiv_pkg::*;

  localparam int CW = $clog2(ITERS);

  muldiv_state_e   state_r;
  muldiv_state_e   state_nx_s;
  logic [CW-1:0]   cnt_r;
  muldiv_op_e      op_r;
  logic [4:0]      rd_r;
  logic            neg_r;
  logic [63:0]     acc_r;
  logic [31:0]     opb_r;
  logic            busy_r;
  logic            done_r;
  logic [31:0]     result_r;
  logic [4:0]      rd_out_r;

  muldiv_op_e      op_in_s;
  logic            a_neg_s;
  logic            b_neg_s;
  logic [31:0]     a_mag_s;
  logic [31:0]     b_mag_s;
  logic            div0_s;
  logic            ovf_s;
  logic            special_s;
  logic [31:0]     special_res_s;
  logic            neg_in_s;
  logic [32:0]     sum_s;
  logic [32:0]     rem_sh_s;
  logic [32:0]     diff_s;
  logic [63:0]     step_s;
  logic [63:0]     prod_fix_s;
  logic [31:0]     fin_s;

  assign op_in_s = muldiv_op_e'(mdu.funct3);
  assign a_neg_s = a_is_signed(op_in_s) & mdu.op_a[31];
  assign b_neg_s = b_is_signed(op_in_s) & mdu.op_b[31];
  assign a_mag_s = cond_neg(mdu.op_a, a_neg_s);
  assign b_mag_s = cond_neg(mdu.op_b, b_neg_s);

  assign div0_s    = op_is_div(op_in_s) && (mdu.op_b == 32'h0000_0000);
  assign ovf_s     = (op_in_s inside {OP_DIV, OP_REM}) && (mdu.op_a == INT_MIN)
                     && (mdu.op_b == 32'hFFFF_FFFF);
  assign special_s = div0_s | ovf_s;

  // Fast-path results for divide-by-zero and signed overflow
  always_comb begin
    special_res_s = 32'h0000_0000;
    if (div0_s) begin
      special_res_s = op_is_rem(op_in_s) ? mdu.op_a : DIV0_QUOT;
    end else if (ovf_s) begin
      special_res_s = op_is_rem(op_in_s) ? 32'h0000_0000 : INT_MIN;
    end else begin
      special_res_s = 32'h0000_0000;
    end
  end

  // Result sign: remainder follows the dividend, everything else the xor of signs
  always_comb begin
    neg_in_s = 1'b0;
    case (op_in_s)
      OP_MULH, OP_DIV: neg_in_s = a_neg_s ^ b_neg_s;
      OP_MULHSU, OP_REM: neg_in_s = a_neg_s;
      default: neg_in_s = 1'b0;
    endcase
  end

  // One iteration: acc holds {hi/remainder, multiplier/quotient}
  always_comb begin
    sum_s    = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opb_r} : 33'd0);
    rem_sh_s = acc_r[63:31];
    diff_s   = rem_sh_s - {1'b0, opb_r};
    step_s   = 64'd0;
    if (op_is_div(op_r)) begin
      if (!diff_s[32]) begin
        step_s = {diff_s[31:0], acc_r[30:0], 1'b1};
      end else begin
        step_s = {rem_sh_s[31:0], acc_r[30:0], 1'b0};
      end
    end else begin
      step_s = {sum_s, acc_r[31:1]};
    end
  end

  assign prod_fix_s = neg_r ? (64'd0 - step_s) : step_s;

  // Sign-corrected result selection applied on the final iteration
  always_comb begin
    fin_s = 32'h0000_0000;
    case (op_r)
      OP_MUL:                       fin_s = step_s[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_s = prod_fix_s[63:32];
      OP_DIV, OP_DIVU:              fin_s = cond_neg(step_s[31:0], neg_r);
      OP_REM, OP_REMU:              fin_s = cond_neg(step_s[63:32], neg_r);
      default:                      fin_s = 32'h0000_0000;
    endcase
  end

  // Next-state logic; flush overrides every state
  always_comb begin
    state_nx_s = state_r;
    if (mdu.flush) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (mdu.start) begin
            state_nx_s = special_s ? DONE : COMPUTE;
          end else begin
            state_nx_s = IDLE;
          end
        end
        COMPUTE: begin
          if (cnt_r == {CW{1'b0}}) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = COMPUTE;
          end
        end
        DONE:    state_nx_s = IDLE;
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // State register, status flags and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      op_r     <= OP_MUL;
      rd_r     <= 5'd0;
      neg_r    <= 1'b0;
      acc_r    <= 64'd0;
      opb_r    <= 32'h0000_0000;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= 32'h0000_0000;
      rd_out_r <= 5'd0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == COMPUTE) || (state_nx_s == DONE);
      done_r  <= (state_nx_s == DONE);
      if (!mdu.flush) begin
        case (state_r)
          IDLE: begin
            if (mdu.start) begin
              op_r  <= op_in_s;
              rd_r  <= mdu.rd_in;
              neg_r <= neg_in_s;
              acc_r <= {32'h0000_0000, a_mag_s};
              opb_r <= b_mag_s;
              cnt_r <= CW'(ITERS - 1);
              if (special_s) begin
                result_r <= special_res_s;
                rd_out_r <= mdu.rd_in;
              end
            end
          end
          COMPUTE: begin
            acc_r <= step_s;
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == {CW{1'b0}}) begin
              result_r <= fin_s;
              rd_out_r <= rd_r;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // rst_n gating keeps the hazard unit quiet while the unit is held in reset
  assign mdu.stall_req = rst_n & (((state_r == IDLE) & mdu.start & ~mdu.flush)
                                  | (state_r == COMPUTE));
  assign mdu.busy   = busy_r;
  assign mdu.done   = done_r;
  assign mdu.result = result_r;
  assign mdu.rd_out = rd_out_r;

endmodule
